rrc_matched_rx: RTL
===================

// Module: rrc_matched_rx
// PURPOSE
//  Receive-side counterpart of the QAM16 transmit pulse shaper, applied to one axis (I or Q).
//  - Applies the same 11-tap symmetric matched filter {4,6,8,10,12,14,12,10,8,6,4} to the
//    16-bit shaped stream.
//  - Decimates to symbol rate and slices each symbol to one of 4 PAM levels (Gray-coded).
//  - Buffers decisions in a 2-entry FIFO with a valid/ready handshake toward the demapper.
//  - One instance per axis.
// PARAMETERS
//  SPS     1      samples per symbol on din (1..16)
//  PHASE   0      sample index within symbol at which a decision is taken (0..SPS-1)
//  THRESH  17672  outer decision threshold on filt_out (=2*94*94, midpoint of levels 1 and 3)
// PORTS
//  clk        in   1   clock
//  rst        in   1   reset, synchronous, active-high
//  din        in   16  signed shaped sample from the channel / transmit filter
//  din_valid  in   1   din accepted on this edge
//  sym_ready  in   1   downstream accepts sym this edge
//  sym        out  2   Gray-coded level: -3=00, -1=01, +1=11, +3=10
//  sym_valid  out  1   FIFO head valid
//  filt_out   out  28  signed matched-filter output (registered)
//  filt_valid out  1   one-cycle strobe, filt_out updated
//  locked     out  1   1 when state==RUN
//  overflow   out  1   sticky: a decision was dropped because the FIFO was full
// BEHAVIOUR
//  Reset
//   - All outputs 0; shift register, phase counter and fill counter 0; FIFO empty; state FILL.
//   - Reset mid-operation discards all pipeline and FIFO contents in the same edge.
//  Shift register
//   - 11 x 16-bit taps; shifts only on din_valid edges (din enters tap 0).
//   - din_valid low: taps, counters and filter hold.
//  Filter
//   - acc = sum(tap[i]*coef[i]): 16x8 signed products, 28-bit signed sum; no saturation
//     (28 bits cannot overflow).
//   - filt_out/filt_valid are registered 1 edge after the shift edge.
//   - Sample accepted at edge k is included in filt_out after edge k+1.
//   - filt_valid pulses for every accepted sample, in both FILL and RUN.
//  State machine
//   - FILL: counts accepted samples; after the 11th accepted sample -> RUN
//     (that sample's output is the first eligible).
//   - RUN: stays until rst.
//  Decimation
//   - Phase counter increments per accepted sample, wraps SPS-1 -> 0, and runs in FILL too.
//   - A decision is taken for the filter output whose sample had phase == PHASE,
//     only if the state was RUN when that sample was accepted.
//  Slicer (registered, edge k+2)
//   - acc >= THRESH -> +3
//   - 0 <= acc < THRESH -> +1
//   - -THRESH <= acc < 0 -> -1
//   - acc < -THRESH -> -3
//   - Exact-boundary values map upward as listed.
//  FIFO and handshake
//   - 2 entries; write at edge k+2, so sym_valid rises after edge k+2 if the FIFO was empty.
//   - Pop when sym_valid & sym_ready; sym, sym_valid depend only on FIFO state (no comb path
//     from sym_ready).
//   - Full + write + pop same edge: write accepted, no overflow.
//   - Full + write, no pop: new decision dropped, FIFO unchanged, overflow set.
//   - Empty + pop attempt: ignored.
//  Timing
//   - Sustains one sample per clock, SPS=1, with sym_ready held high.
// TESTING
//  1. SPS=1, din=282 constant for 20 valids, sym_ready=1:
//     - filt_out settles to 26508 from the 11th sample; locked=1 after 11th accept;
//     - sym=10 on every sym_valid; first sym_valid 2 edges after the 11th accept.
//  2. Impulse:
//     - din=1 for one valid then 0s: filt_out sequence 4,6,8,10,12,14,12,10,8,6,4,0.
//     - din=-94 constant: filt_out=-8836, sym=01.
//  3. Threshold edges: drive so acc = 17672 -> 10; 17671 -> 11; 0 -> 11; -1 -> 01;
//     -17672 -> 01; -17673 -> 00.
//  4. sym_ready=0, 3 decisions in RUN:
//     - FIFO holds first two, overflow=1, third lost.
//     - Then ready=1 pops 2 in order, sym_valid drops; overflow stays 1.
//  5. SPS=4, PHASE=2, din_valid every other cycle:
//     - one decision per 4 accepted samples, taken at phase-2 samples only;
//     - gaps in din_valid do not advance any counter.
//  6. rst asserted mid-stream with FIFO full:
//     - next edge sym_valid=0, locked=0, overflow=0, filt_out=0;
//     - FILL repeats and 11 new samples are needed before any decision.

Source files
------------

// File: rtl/rrc_matched_rx_if.sv
// rtl/rrc_matched_rx_if.sv - sample input, filter monitor and symbol handshake bundle
interface rrc_matched_rx_if;
  logic signed [15:0] din;
  logic               din_valid;
  logic               sym_ready;
  logic        [1:0]  sym;
  logic               sym_valid;
  logic signed [27:0] filt_out;
  logic               filt_valid;
  logic               locked;
  logic               overflow;

  modport master (
    output din, din_valid, sym_ready,
    input  sym, sym_valid, filt_out, filt_valid, locked, overflow
  );

  modport slave (
    input  din, din_valid, sym_ready,
    output sym, sym_valid, filt_out, filt_valid, locked, overflow
  );
endinterface

// File: rtl/rrc_matched_rx.sv
// rtl/rrc_matched_rx.sv - 11-tap matched filter, symbol-rate decimator, 4-level slicer, 2-deep FIFO
module rrc_matched_rx #(
  parameter int SPS    = 1,
  parameter int PHASE  = 0,
  parameter int THRESH = 17672
) (
  input  logic               clk,
  input  logic               rst,
  rrc_matched_rx_if.slave    bus
);
  typedef enum logic {FILL, RUN} state_t;

  localparam logic signed [7:0] COEF [11] = '{8'sd4, 8'sd6, 8'sd8, 8'sd10, 8'sd12, 8'sd14,
                                               8'sd12, 8'sd10, 8'sd8, 8'sd6, 8'sd4};
  localparam logic signed [27:0] TH_POS  = 28'(THRESH);
  localparam logic signed [27:0] TH_NEG  = 28'(-THRESH);
  localparam logic        [3:0]  PH_LAST = 4'(SPS - 1);
  localparam logic        [3:0]  PH_TAKE = 4'(PHASE);

  state_t             state;
  logic signed [15:0] taps [11];
  logic        [3:0]  fill_cnt;
  logic        [3:0]  phase_cnt;
  logic               s1_valid;
  logic               s1_take;
  logic               s2_take;
  logic signed [27:0] acc;
  logic        [1:0]  slice;
  logic        [1:0]  fifo_mem [2];
  logic               rd_ptr;
  logic               wr_ptr;
  logic        [1:0]  count;
  logic               full;
  logic               pop;
  logic               push;

  always_comb begin
    acc = '0;
    for (int i = 0; i < 11; i++)
      acc = acc + 28'(taps[i]) * 28'(COEF[i]);
  end

  // Gray code: -3=00, -1=01, +1=11, +3=10; ties round toward the upper level
  always_comb begin
    slice = 2'b00;
    if (bus.filt_out >= TH_POS)
      slice = 2'b10;
    else if (bus.filt_out >= 28'sd0)
      slice = 2'b11;
    else if (bus.filt_out >= TH_NEG)
      slice = 2'b01;
  end

  assign full          = (count == 2'd2);
  assign pop           = (count != 2'd0) && bus.sym_ready;
  assign push          = s2_take && (!full || pop);
  assign bus.sym       = fifo_mem[rd_ptr];
  assign bus.sym_valid = (count != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= FILL;
      fill_cnt       <= '0;
      phase_cnt      <= '0;
      s1_valid       <= 1'b0;
      s1_take        <= 1'b0;
      s2_take        <= 1'b0;
      rd_ptr         <= 1'b0;
      wr_ptr         <= 1'b0;
      count          <= '0;
      bus.filt_out   <= '0;
      bus.filt_valid <= 1'b0;
      bus.locked     <= 1'b0;
      bus.overflow   <= 1'b0;
      for (int i = 0; i < 11; i++) taps[i] <= '0;
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
    end else begin
      s1_valid <= bus.din_valid;
      // The sample that completes the fill is already eligible for a decision
      s1_take  <= bus.din_valid && (phase_cnt == PH_TAKE) &&
                  ((state == RUN) || (fill_cnt == 4'd10));
      s2_take  <= s1_take;

      if (bus.din_valid) begin
        taps[0] <= bus.din;
        for (int i = 1; i < 11; i++) taps[i] <= taps[i-1];
        phase_cnt <= (phase_cnt == PH_LAST) ? 4'd0 : phase_cnt + 4'd1;
        if (state == FILL) begin
          if (fill_cnt == 4'd10) begin
            state      <= RUN;
            bus.locked <= 1'b1;
          end else begin
            fill_cnt <= fill_cnt + 4'd1;
          end
        end
      end

      bus.filt_valid <= s1_valid;
      if (s1_valid) bus.filt_out <= acc;

      // When full, wr_ptr equals rd_ptr, so a simultaneous pop frees the slot being written
      if (push) begin
        fifo_mem[wr_ptr] <= slice;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (s2_take && full && !pop) bus.overflow <= 1'b1;
    end
  end
endmodule
